// File: rtl/btn_pkg.sv
// Shared types and timing constants for the button debounce path.
package btn_pkg;

  // Debounce FSM states. All four 2-bit codes are assigned.
  typedef enum logic [1:0] {
    S_LOW  = 2'b00,
    S_RISE = 2'b01,
    S_HIGH = 2'b10,
    S_FALL = 2'b11
  } btn_state_e;

  // Default timing for a 100 MHz clock.
  localparam int DEBOUNCE_1MS  = 100_000;
  localparam int HOLD_500MS    = 50_000_000;
  localparam int REPEAT_100MS  = 10_000_000;

  // Larger of two integers, used to size the shared hold/repeat counter.
  function automatic int max_int(input int a, input int b);
    if (a > b) begin
      return a;
    end else begin
      return b;
    end
  endfunction

endpackage

// File: rtl/btn_debounce_pulse_if.sv
// Button bundle: synchronized level in, debounced level and strobes out.
// The release strobe is named rel because "release" is a reserved word.
interface btn_debounce_pulse_if;
  logic din;
  logic level;
  logic press;
  logic rel;
  logic rpt;

  modport master (output din, input level, input press, input rel, input rpt);
  modport slave  (input din, output level, output press, output rel, output rpt);
endinterface

// File: rtl/btn_debounce_pulse.sv
// Debounces a synchronized button level and produces one-cycle press,
// release and auto-repeat strobes. A single 4-state FSM with a stability
// counter (shared by both edges) and a hold/repeat counter.
module btn_debounce_pulse
  import btn_pkg::*;
#(
  parameter int STABLE_CYCLES = DEBOUNCE_1MS,
  parameter int HOLD_CYCLES   = HOLD_500MS,
  parameter int REPEAT_CYCLES = REPEAT_100MS,
  parameter bit REPEAT_EN     = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  btn_debounce_pulse_if.slave  bus
);

  localparam int SW = $clog2(STABLE_CYCLES + 1);
  localparam int HW = $clog2(max_int(HOLD_CYCLES, REPEAT_CYCLES) + 1);

  localparam logic [SW-1:0] STAB_LAST = SW'(STABLE_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
  localparam logic [HW-1:0] REP_LAST  = HW'(REPEAT_CYCLES - 1);

  btn_state_e      state_q, state_d;
  logic [SW-1:0]   stab_cnt_q, stab_cnt_d;
  logic [HW-1:0]   hold_cnt_q, hold_cnt_d;
  logic            rep_phase_q, rep_phase_d;
  logic            level_q, level_d;
  logic            press_q, press_d;
  logic            rel_q, rel_d;
  logic            rpt_q, rpt_d;

  // Next-state, counter and strobe decode; strobes default low every cycle.
  always_comb begin
    state_d     = state_q;
    stab_cnt_d  = stab_cnt_q;
    hold_cnt_d  = hold_cnt_q;
    rep_phase_d = rep_phase_q;
    level_d     = level_q;
    press_d     = 1'b0;
    rel_d       = 1'b0;
    rpt_d       = 1'b0;

    case (state_q)
      S_LOW: begin
        level_d = 1'b0;
        if (bus.din) begin
          state_d    = S_RISE;
          stab_cnt_d = {SW{1'b0}};
        end else begin
          state_d = S_LOW;
        end
      end

      S_RISE: begin
        level_d = 1'b0;
        if (!bus.din) begin
          // Bounce rejected silently.
          state_d = S_LOW;
        end else if (stab_cnt_q == STAB_LAST) begin
          state_d     = S_HIGH;
          level_d     = 1'b1;
          press_d     = 1'b1;
          hold_cnt_d  = {HW{1'b0}};
          rep_phase_d = 1'b0;
        end else begin
          stab_cnt_d = stab_cnt_q + SW'(1);
        end
      end

      S_HIGH: begin
        level_d = 1'b1;
        if (!bus.din) begin
          // hold_cnt is frozen, so a release glitch only delays the repeat.
          state_d    = S_FALL;
          stab_cnt_d = {SW{1'b0}};
        end else if (REPEAT_EN) begin
          if (!rep_phase_q && (hold_cnt_q == HOLD_LAST)) begin
            rpt_d       = 1'b1;
            hold_cnt_d  = {HW{1'b0}};
            rep_phase_d = 1'b1;
          end else if (rep_phase_q && (hold_cnt_q == REP_LAST)) begin
            rpt_d      = 1'b1;
            hold_cnt_d = {HW{1'b0}};
          end else begin
            hold_cnt_d = hold_cnt_q + HW'(1);
          end
        end else begin
          hold_cnt_d = hold_cnt_q;
        end
      end

      S_FALL: begin
        level_d = 1'b1;
        if (bus.din) begin
          // Glitch: resume holding with counters untouched.
          state_d = S_HIGH;
        end else if (stab_cnt_q == STAB_LAST) begin
          state_d = S_LOW;
          level_d = 1'b0;
          rel_d   = 1'b1;
        end else begin
          stab_cnt_d = stab_cnt_q + SW'(1);
        end
      end

      default: begin
        state_d     = S_LOW;
        stab_cnt_d  = {SW{1'b0}};
        hold_cnt_d  = {HW{1'b0}};
        rep_phase_d = 1'b0;
        level_d     = 1'b0;
      end
    endcase
  end

  // State, counters and registered outputs; synchronous reset wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_LOW;
      stab_cnt_q  <= {SW{1'b0}};
      hold_cnt_q  <= {HW{1'b0}};
      rep_phase_q <= 1'b0;
      level_q     <= 1'b0;
      press_q     <= 1'b0;
      rel_q       <= 1'b0;
      rpt_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      stab_cnt_q  <= stab_cnt_d;
      hold_cnt_q  <= hold_cnt_d;
      rep_phase_q <= rep_phase_d;
      level_q     <= level_d;
      press_q     <= press_d;
      rel_q       <= rel_d;
      rpt_q       <= rpt_d;
    end
  end

  assign bus.level = level_q;
  assign bus.press = press_q;
  assign bus.rel   = rel_q;
  assign bus.rpt   = rpt_q;

endmodule

// File: tb/tb_btn_debounce_pulse.sv
// Directed bench for btn_debounce_pulse: STABLE=4, HOLD=10, REPEAT=3.
// A second instance with auto-repeat disabled shares clock, reset and din.
module tb_btn_debounce_pulse;

  logic clk = 1'b0;
  logic rst;

  btn_debounce_pulse_if bus1 ();
  btn_debounce_pulse_if bus2 ();

  btn_debounce_pulse #(
    .STABLE_CYCLES(4), .HOLD_CYCLES(10), .REPEAT_CYCLES(3), .REPEAT_EN(1'b1)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus1)
  );

  btn_debounce_pulse #(
    .STABLE_CYCLES(4), .HOLD_CYCLES(10), .REPEAT_CYCLES(3), .REPEAT_EN(1'b0)
  ) dut_norpt (
    .clk(clk), .rst(rst), .bus(bus2)
  );

  // 10 ns clock.
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  int press1_cnt = 0;
  int rel1_cnt   = 0;
  int rpt1_cnt   = 0;
  int press2_cnt = 0;
  int rel2_cnt   = 0;
  int rpt2_cnt   = 0;

  // Strobe counters sampled mid-cycle.
  always @(negedge clk) begin
    if (bus1.press === 1'b1) press1_cnt <= press1_cnt + 1;
    if (bus1.rel   === 1'b1) rel1_cnt   <= rel1_cnt + 1;
    if (bus1.rpt   === 1'b1) rpt1_cnt   <= rpt1_cnt + 1;
    if (bus2.press === 1'b1) press2_cnt <= press2_cnt + 1;
    if (bus2.rel   === 1'b1) rel2_cnt   <= rel2_cnt + 1;
    if (bus2.rpt   === 1'b1) rpt2_cnt   <= rpt2_cnt + 1;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_din(input logic v);
    bus1.din = v;
    bus2.din = v;
  endtask

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    logic e;

    // Reset state
    rst = 1'b1;
    set_din(1'b0);
    step();
    step();
    chk("rst_level", bus1.level, 1'b0);
    chk("rst_press", bus1.press, 1'b0);
    chk("rst_rel",   bus1.rel,   1'b0);
    chk("rst_rpt",   bus1.rpt,   1'b0);
    rst = 1'b0;

    // Clean press on the 5th sampled-1 edge, then hold with repeats
    set_din(1'b1);
    for (int i = 1; i <= 4; i++) begin
      step();
      chk("t1_press_early", bus1.press, 1'b0);
      chk("t1_level_early", bus1.level, 1'b0);
    end
    step();  // edge E
    chk("t1_press",      bus1.press, 1'b1);
    chk("t1_level",      bus1.level, 1'b1);
    chk("t1_press_nrpt", bus2.press, 1'b1);
    for (int k = 1; k <= 20; k++) begin
      step();  // edge E+k
      e = (k >= 10) && (((k - 10) % 3) == 0);
      chk("t4_rpt",      bus1.rpt,   e);
      chk("t1_press_1c", bus1.press, 1'b0);
      chk("t1_level_hi", bus1.level, 1'b1);
      chk("t1_rel_none", bus1.rel,   1'b0);
      chk("t4_rpt_off",  bus2.rpt,   1'b0);
    end

    // Release glitch (2 low edges), back high: repeat resumes late
    set_din(1'b0);
    for (int i = 1; i <= 2; i++) begin  // E+21, E+22
      step();
      chk("t3_glitch_level", bus1.level, 1'b1);
      chk("t3_glitch_rel",   bus1.rel,   1'b0);
      chk("t3_glitch_rpt",   bus1.rpt,   1'b0);
    end
    set_din(1'b1);
    step();  // E+23: back to S_HIGH
    chk("t3_back_rel", bus1.rel, 1'b0);
    chk("t3_back_rpt", bus1.rpt, 1'b0);
    step();  // E+24
    chk("t3_frozen_rpt0", bus1.rpt, 1'b0);
    step();  // E+25
    chk("t3_frozen_rpt1", bus1.rpt, 1'b1);

    // Real release on the 5th sampled-0 edge
    set_din(1'b0);
    for (int i = 1; i <= 4; i++) begin
      step();
      chk("t3_rel_early",   bus1.rel,   1'b0);
      chk("t3_level_early", bus1.level, 1'b1);
      chk("t3_fall_rpt",    bus1.rpt,   1'b0);
    end
    step();
    chk("t3_rel",       bus1.rel,   1'b1);
    chk("t3_rel_level", bus1.level, 1'b0);
    step();
    chk("t3_rel_1c",    bus1.rel,   1'b0);
    chk("t3_level_low", bus1.level, 1'b0);

    // Rising bounce: 3 high edges then 1 low, five times
    for (int r = 0; r < 5; r++) begin
      set_din(1'b1);
      for (int i = 0; i < 3; i++) begin
        step();
        chk("t2_press", bus1.press, 1'b0);
        chk("t2_level", bus1.level, 1'b0);
        chk("t2_rpt",   bus1.rpt,   1'b0);
      end
      set_din(1'b0);
      step();
      chk("t2_level_low", bus1.level, 1'b0);
    end

    // Reset mid-hold
    set_din(1'b1);
    for (int i = 0; i < 4; i++) step();
    step();
    chk("t5_press", bus1.press, 1'b1);
    for (int i = 0; i < 3; i++) step();
    rst = 1'b1;
    step();
    chk("t5_rst_level", bus1.level, 1'b0);
    chk("t5_rst_rel",   bus1.rel,   1'b0);
    chk("t5_rst_press", bus1.press, 1'b0);
    chk("t5_rst_rpt",   bus1.rpt,   1'b0);
    rst = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      step();
      chk("t5_repress_early", bus1.press, 1'b0);
      chk("t5_relevel_early", bus1.level, 1'b0);
      chk("t5_no_rel",        bus1.rel,   1'b0);
    end
    step();
    chk("t5_repress", bus1.press, 1'b1);
    chk("t5_relevel", bus1.level, 1'b1);

    // Reset on the edge that would complete debounce
    rst = 1'b1;
    set_din(1'b0);
    step();
    rst = 1'b0;
    set_din(1'b1);
    for (int i = 0; i < 4; i++) begin  // S_RISE with stab_cnt=3
      step();
      chk("t6_pre_press", bus1.press, 1'b0);
    end
    rst = 1'b1;
    step();
    chk("t6_press", bus1.press, 1'b0);
    chk("t6_level", bus1.level, 1'b0);
    chk("t6_rel",   bus1.rel,   1'b0);
    chk("t6_rpt",   bus1.rpt,   1'b0);
    rst = 1'b0;
    for (int i = 1; i <= 4; i++) begin  // restarts from S_LOW
      step();
      chk("t6_after_early", bus1.press, 1'b0);
      chk("t6_after_level", bus1.level, 1'b0);
    end
    step();
    chk("t6_after_press", bus1.press, 1'b1);
    chk("t6_after_level1", bus1.level, 1'b1);

    // Strobe totals over the whole run
    @(negedge clk);
    #1;
    chk_int("tot_press1", press1_cnt, 4);
    chk_int("tot_rel1",   rel1_cnt,   1);
    chk_int("tot_rpt1",   rpt1_cnt,   5);
    chk_int("tot_press2", press2_cnt, 4);
    chk_int("tot_rel2",   rel2_cnt,   1);
    chk_int("tot_rpt2",   rpt2_cnt,   0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
